// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller for the 5-stage pipeline
//
// Keeps a shadow scoreboard of the instructions in EX, MEM and WB and uses it
// to detect load-use, no-forwarding RAW and flag hazards against the ID
// instruction. Combines these with branch redirects and memory-busy freezes
// into PC / pipeline-register strobes, and counts stall and flush events.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   id_valid                   ID holds a real instruction
//   id_rn, id_rm               ID source registers
//   id_rn_used, id_rm_used     corresponding source is actually read
//   id_rd, id_regwrite         ID destination and its write enable
//   id_memtoreg                ID instruction is a load
//   id_update, id_cond         ID sets flags / ID reads flags (B.cond)
//   br_taken_ex                taken branch resolved in EX
//   mem_busy                   data memory not ready, freeze everything
//   pc_en, if_id_en            PC and IF/ID load enables
//   if_id_flush, id_ex_flush   bubble strobes for IF/ID and ID/EX
//   pipe_freeze                hold ID/EX, EX/MEM, MEM/WB
//   stall_cycles, flush_count  saturating performance counters

module pipe_hazard_ctrl #(
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_rn_used,
    input  logic             id_rm_used,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memtoreg,
    input  logic             id_update,
    input  logic             id_cond,
    input  logic             br_taken_ex,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [4:0]       XZR     = 5'd31;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       regwrite;
        logic       load;
        logic       update;
    } slot_t;

    slot_t ex_q, ex_d;
    slot_t mem_q, mem_d;
    slot_t wb_q, wb_d;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic ex_match;
    logic mem_match;
    logic load_use;
    logic raw_nofwd;
    logic flag_haz;
    logic hazard;
    logic stall_inc;
    logic flush_inc;

    // Hazard detection against the registered scoreboard.
    always_comb begin
        ex_match  = ex_q.v && ex_q.regwrite && (ex_q.rd != XZR) &&
                    ((id_rn_used && (id_rn == ex_q.rd)) ||
                     (id_rm_used && (id_rm == ex_q.rd)));
        mem_match = mem_q.v && mem_q.regwrite && (mem_q.rd != XZR) &&
                    ((id_rn_used && (id_rn == mem_q.rd)) ||
                     (id_rm_used && (id_rm == mem_q.rd)));

        load_use  = id_valid && ex_match && ex_q.load;
        // WB never stalls: the regfile writes in the first half-cycle.
        raw_nofwd = !FWD_EN && id_valid && (ex_match || mem_match);
        flag_haz  = id_valid && id_cond && ex_q.v && ex_q.update;
        hazard    = load_use || raw_nofwd || flag_haz;
    end

    // Strobe priority: reset, memory freeze, branch redirect, hazard stall.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_freeze = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        if (reset) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (mem_busy) begin
            // The EX branch is held too, so a pending redirect is seen again
            // once the memory is ready.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            pipe_freeze = 1'b1;
        end else if (br_taken_ex) begin
            // ID is squashed, so any hazard it carries is irrelevant.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc   = 1'b1;
        end else if (hazard) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
        end
    end

    // Scoreboard shift and saturating counters.
    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (!pipe_freeze) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (id_ex_flush || !id_valid) begin
                ex_d = '0;
            end else begin
                ex_d = {1'b1, id_rd, id_regwrite, id_memtoreg, id_update};
            end
        end

        if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (flush_inc && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // The WB entry is tracked so the shadow matches the real pipeline, but it
    // never participates in hazard detection.
    logic wb_unused;
    assign wb_unused = ^wb_q;

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

endmodule
